// File: rtl/button_array_unit.sv
`default_nettype none
// button_array_unit: N-channel button front end with synchronizer, tick-sampled
// debounce and press / long-press / auto-repeat / release pulse generation.
module button_array_unit #(
  parameter int N            = 4,
  parameter int sim          = 0,
  parameter int DEB_SAMPLES  = 4,
  parameter int LONG_TICKS   = 100,
  parameter int REPEAT_TICKS = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] ButtonIn,
  input  logic [N-1:0] repeat_en,
  output logic [N-1:0] ButtonOut,
  output logic [N-1:0] release_out,
  output logic [N-1:0] long_out,
  output logic [N-1:0] level_out
);

  localparam int TICK_DIV = (sim != 0) ? 4 : 500000;
  localparam int TICK_W   = $clog2(TICK_DIV);
  localparam int DEB_W    = $clog2(16);
  localparam int HOLD_W   = $clog2(1024);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_SAMPLES - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_TICKS - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } state_t;

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [1:0]        sync_ff;
    logic              level;
    logic              level_nxt;
    logic              rise;
    logic              fall;
    logic [DEB_W-1:0]  deb_cnt;
    logic [DEB_W-1:0]  deb_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    state_t            state;
    logic              press_q;
    logic              release_q;
    logic              long_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync_ff <= '0;
      end else begin
        sync_ff <= {sync_ff[0], ButtonIn[i]};
      end
    end

    always_comb begin
      level_nxt = level;
      deb_nxt   = deb_cnt;
      if (tick) begin
        if (sync_ff[1] != level) begin
          if (deb_cnt == DEB_LAST) begin
            level_nxt = ~level;
            deb_nxt   = '0;
          end else begin
            deb_nxt = deb_cnt + DEB_W'(1);
          end
        end else begin
          deb_nxt = '0;
        end
      end
    end

    // The FSM reacts on the same edge the debounced level flips.
    assign rise = level_nxt & ~level;
    assign fall = level & ~level_nxt;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        level   <= 1'b0;
        deb_cnt <= '0;
      end else begin
        level   <= level_nxt;
        deb_cnt <= deb_nxt;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state     <= IDLE;
        hold_cnt  <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        // A falling level pre-empts any threshold reached on the same tick.
        if (fall) begin
          state     <= IDLE;
          hold_cnt  <= '0;
          release_q <= 1'b1;
        end else begin
          case (state)
            IDLE: begin
              if (rise) begin
                state    <= PRESSED;
                hold_cnt <= '0;
                press_q  <= 1'b1;
              end
            end
            PRESSED: begin
              if (tick) begin
                if (hold_cnt == LONG_LAST) begin
                  state    <= HELD;
                  hold_cnt <= '0;
                  long_q   <= 1'b1;
                end else begin
                  hold_cnt <= hold_cnt + HOLD_W'(1);
                end
              end
            end
            HELD: begin
              if (!repeat_en[i]) begin
                hold_cnt <= '0;
              end else if (tick) begin
                if (hold_cnt == REP_LAST) begin
                  hold_cnt <= '0;
                  press_q  <= 1'b1;
                end else begin
                  hold_cnt <= hold_cnt + HOLD_W'(1);
                end
              end
            end
            default: begin
              state    <= IDLE;
              hold_cnt <= '0;
            end
          endcase
        end
      end
    end

    assign ButtonOut[i]   = press_q;
    assign release_out[i] = release_q;
    assign long_out[i]    = long_q;
    assign level_out[i]   = level;
  end

endmodule
`default_nettype wire

// File: tb/tb_button_array_unit.sv
`default_nettype none
// tb_button_array_unit: directed scenarios for button_array_unit with sim=1
// (4 clk per tick), DEB_SAMPLES=4, LONG_TICKS=8, REPEAT_TICKS=3.
module tb_button_array_unit;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] ButtonIn = '0;
  logic [N-1:0] repeat_en = '0;
  logic [N-1:0] ButtonOut;
  logic [N-1:0] release_out;
  logic [N-1:0] long_out;
  logic [N-1:0] level_out;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  int press_cnt   [N];
  int rel_cnt     [N];
  int long_cnt    [N];
  int first_press [N];
  int press_t     [8];
  int long_t      = 0;
  int viol        = 0;
  bit lvl1_seen   = 1'b0;
  logic [N-1:0] prev_b = '0;
  logic [N-1:0] prev_r = '0;
  logic [N-1:0] prev_l = '0;

  button_array_unit #(
    .N            (N),
    .sim          (1),
    .DEB_SAMPLES  (4),
    .LONG_TICKS   (8),
    .REPEAT_TICKS (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ButtonIn    (ButtonIn),
    .repeat_en   (repeat_en),
    .ButtonOut   (ButtonOut),
    .release_out (release_out),
    .long_out    (long_out),
    .level_out   (level_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse bookkeeping sampled mid-cycle; also flags wide or overlapping pulses.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (ButtonOut[i]) begin
        if (press_cnt[i] == 0) first_press[i] = cyc;
        if (i == 2 && press_cnt[i] < 8) press_t[press_cnt[i]] = cyc;
        press_cnt[i]++;
      end
      if (release_out[i]) rel_cnt[i]++;
      if (long_out[i]) begin
        long_cnt[i]++;
        if (i == 2) long_t = cyc;
      end
      if (32'(ButtonOut[i]) + 32'(release_out[i]) + 32'(long_out[i]) > 1) viol++;
    end
    if (level_out[1]) lvl1_seen = 1'b1;
    viol += $countones((ButtonOut & prev_b) | (release_out & prev_r) | (long_out & prev_l));
    prev_b = ButtonOut;
    prev_r = release_out;
    prev_l = long_out;
  end

  task automatic clear_stats();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      press_cnt[i] = 0;
      rel_cnt[i] = 0;
      long_cnt[i] = 0;
      first_press[i] = 0;
    end
    for (int i = 0; i < 8; i++) press_t[i] = 0;
    long_t = 0;
    lvl1_seen = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if (ButtonOut !== 4'b0000) begin
      errors++;
      $display("FAIL reset_buttonout: got %b expected 0000", ButtonOut);
    end
    vectors++;
    if (release_out !== 4'b0000) begin
      errors++;
      $display("FAIL reset_release: got %b expected 0000", release_out);
    end
    vectors++;
    if (long_out !== 4'b0000) begin
      errors++;
      $display("FAIL reset_long: got %b expected 0000", long_out);
    end
    vectors++;
    if (level_out !== 4'b0000) begin
      errors++;
      $display("FAIL reset_level: got %b expected 0000", level_out);
    end
    reset = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_clean_press();
    int c0;
    int lat;
    clear_stats();
    @(negedge clk);
    ButtonIn[0] = 1'b1;
    c0 = cyc;
    repeat (24) @(negedge clk);
    vectors++;
    if (level_out[0] !== 1'b1) begin
      errors++;
      $display("FAIL clean_level_high: got %b expected 1", level_out[0]);
    end
    ButtonIn[0] = 1'b0;
    repeat (30) @(negedge clk);
    lat = first_press[0] - c0;
    vectors++;
    if (press_cnt[0] != 1) begin
      errors++;
      $display("FAIL clean_press_count: got %0d expected 1", press_cnt[0]);
    end
    vectors++;
    if (press_cnt[0] == 0 || lat < 1 || lat > 19) begin
      errors++;
      $display("FAIL clean_press_latency: got %0d clk expected 1..19", lat);
    end
    vectors++;
    if (rel_cnt[0] != 1) begin
      errors++;
      $display("FAIL clean_release_count: got %0d expected 1", rel_cnt[0]);
    end
    vectors++;
    if (long_cnt[0] != 0) begin
      errors++;
      $display("FAIL clean_long_count: got %0d expected 0", long_cnt[0]);
    end
    vectors++;
    if (level_out[0] !== 1'b0) begin
      errors++;
      $display("FAIL clean_level_low: got %b expected 0", level_out[0]);
    end
  endtask

  task automatic test_bounce();
    int total;
    clear_stats();
    @(negedge clk);
    ButtonIn[1] = 1'b1;
    repeat (12) @(negedge clk);
    ButtonIn[1] = 1'b0;
    repeat (30) @(negedge clk);
    vectors++;
    if (lvl1_seen !== 1'b0) begin
      errors++;
      $display("FAIL bounce_level: got level_out[1] high expected always 0");
    end
    total = 0;
    for (int i = 0; i < N; i++) total += press_cnt[i] + rel_cnt[i] + long_cnt[i];
    vectors++;
    if (total != 0) begin
      errors++;
      $display("FAIL bounce_pulses: got %0d pulses expected 0", total);
    end
  endtask

  task automatic test_long_repeat(input bit en);
    int exp_press;
    clear_stats();
    repeat_en[2] = en;
    @(negedge clk);
    ButtonIn[2] = 1'b1;
    repeat (80) @(negedge clk);
    ButtonIn[2] = 1'b0;
    repeat (40) @(negedge clk);
    // 20 held ticks: long at +8, repeats at +11,+14,+17; +20 coincides with release
    exp_press = en ? 4 : 1;
    vectors++;
    if (press_cnt[2] != exp_press) begin
      errors++;
      $display("FAIL long_rep%0d_press_count: got %0d expected %0d", en, press_cnt[2], exp_press);
    end
    vectors++;
    if (long_cnt[2] != 1) begin
      errors++;
      $display("FAIL long_rep%0d_long_count: got %0d expected 1", en, long_cnt[2]);
    end
    vectors++;
    if (long_t - press_t[0] != 32) begin
      errors++;
      $display("FAIL long_rep%0d_long_delay: got %0d clk expected 32", en, long_t - press_t[0]);
    end
    vectors++;
    if (rel_cnt[2] != 1) begin
      errors++;
      $display("FAIL long_rep%0d_release_count: got %0d expected 1", en, rel_cnt[2]);
    end
    if (en) begin
      vectors++;
      if (press_t[1] - long_t != 12) begin
        errors++;
        $display("FAIL repeat_first_gap: got %0d clk expected 12", press_t[1] - long_t);
      end
      vectors++;
      if (press_t[2] - press_t[1] != 12 || press_t[3] - press_t[2] != 12) begin
        errors++;
        $display("FAIL repeat_period: got %0d/%0d clk expected 12/12",
                 press_t[2] - press_t[1], press_t[3] - press_t[2]);
      end
    end
    repeat_en[2] = 1'b0;
  endtask

  task automatic test_simultaneous();
    bit found;
    logic [N-1:0] snap;
    clear_stats();
    found = 1'b0;
    snap = '0;
    @(negedge clk);
    ButtonIn[0] = 1'b1;
    ButtonIn[3] = 1'b1;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      if (ButtonOut != 4'b0000) begin
        found = 1'b1;
        snap = ButtonOut;
      end
    end
    vectors++;
    if (!found || snap !== 4'b1001) begin
      errors++;
      $display("FAIL simul_press: got %b (seen=%0d) expected 1001", snap, found);
    end
    @(negedge clk);
    vectors++;
    if (ButtonOut !== 4'b0000) begin
      errors++;
      $display("FAIL simul_pulse_width: got %b expected 0000", ButtonOut);
    end
    ButtonIn[0] = 1'b0;
    ButtonIn[3] = 1'b0;
    repeat (30) @(negedge clk);
    vectors++;
    if (rel_cnt[0] != 1 || rel_cnt[3] != 1) begin
      errors++;
      $display("FAIL simul_release: got %0d/%0d expected 1/1", rel_cnt[0], rel_cnt[3]);
    end
  endtask

  task automatic test_reset_mid_held();
    bit found;
    clear_stats();
    found = 1'b0;
    repeat_en[2] = 1'b1;
    @(negedge clk);
    ButtonIn[2] = 1'b1;
    for (int k = 0; k < 80 && !found; k++) begin
      @(negedge clk);
      if (long_out[2]) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      errors++;
      $display("FAIL midheld_long_seen: got none expected long_out[2] pulse");
    end
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if ((ButtonOut | release_out | long_out | level_out) !== 4'b0000) begin
      errors++;
      $display("FAIL midheld_async_clear: got %b/%b/%b/%b expected all 0",
               ButtonOut, release_out, long_out, level_out);
    end
    clear_stats();
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    vectors++;
    if (press_cnt[2] != 1 || rel_cnt[2] != 0 || long_cnt[2] != 0) begin
      errors++;
      $display("FAIL midheld_fresh_press: got press=%0d rel=%0d long=%0d expected 1/0/0",
               press_cnt[2], rel_cnt[2], long_cnt[2]);
    end
    vectors++;
    if (level_out[2] !== 1'b1) begin
      errors++;
      $display("FAIL midheld_level: got %b expected 1", level_out[2]);
    end
    ButtonIn[2] = 1'b0;
    repeat_en[2] = 1'b0;
    repeat (30) @(negedge clk);
    vectors++;
    if (rel_cnt[2] != 1) begin
      errors++;
      $display("FAIL midheld_release: got %0d expected 1", rel_cnt[2]);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    repeat (10) @(negedge clk);
    test_bounce();
    repeat (10) @(negedge clk);
    test_long_repeat(1'b1);
    repeat (10) @(negedge clk);
    test_long_repeat(1'b0);
    repeat (10) @(negedge clk);
    test_simultaneous();
    repeat (10) @(negedge clk);
    test_reset_mid_held();
    vectors++;
    if (viol != 0) begin
      errors++;
      $display("FAIL pulse_shape: got %0d wide/overlapping pulses expected 0", viol);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/button_array_unit.md
BUTTON_ARRAY_UNIT -- requirements
Module: button_array_unit

Interface
REQ-001 Parameter N, default 4: number of independent button channels, legal range 1..32.
REQ-002 Parameter sim, default 0: tick divider select; 0 gives TICK_DIV=500000 clk per sample tick, 1 gives TICK_DIV=4.
REQ-003 Parameter DEB_SAMPLES, default 4: consecutive differing sample ticks required to flip a debounced level; legal range 2..15.
REQ-004 Parameter LONG_TICKS, default 100: held ticks from press to long-press event; legal range 2..1023.
REQ-005 Parameter REPEAT_TICKS, default 20: ticks between auto-repeat pulses; legal range 1..1023.
REQ-006 Port clk, input, 1: single clock; all state on its rising edge.
REQ-007 Port reset, input, 1: asynchronous, active-low reset (0 = reset).
REQ-008 Port ButtonIn, input, N: raw asynchronous button levels, 1 = pressed.
REQ-009 Port repeat_en, input, N: per-channel auto-repeat enable, synchronous to clk.
REQ-010 Port ButtonOut, output, N: one-clk press pulse per channel, including auto-repeats.
REQ-011 Port release_out, output, N: one-clk release pulse per channel.
REQ-012 Port long_out, output, N: one-clk long-press pulse per channel.
REQ-013 Port level_out, output, N: debounced button level per channel.

Function
REQ-014 Each channel SHALL pass ButtonIn[i] through a 2-flop synchronizer before any other use.
REQ-015 A single shared tick counter SHALL count 0..TICK_DIV-1, wrap to 0, and assert tick for exactly the one clk in which it equals TICK_DIV-1.
REQ-016 Debounce, per channel, on tick only: synced != level increments deb_cnt; synced == level clears deb_cnt; on reaching DEB_SAMPLES, level toggles and deb_cnt clears.
REQ-017 level_out[i] SHALL equal the registered debounced level; non-tick cycles leave deb_cnt and level unchanged.
REQ-018 Per-channel FSM states SHALL be IDLE, PRESSED, HELD.
REQ-019 IDLE->PRESSED on debounced rising level: ButtonOut[i]=1 for that one clk, hold_cnt cleared.
REQ-020 PRESSED: hold_cnt increments per tick; on reaching LONG_TICKS -> HELD, long_out[i]=1 for one clk, hold_cnt cleared.
REQ-021 HELD with repeat_en[i]=1: hold_cnt increments per tick; on reaching REPEAT_TICKS, ButtonOut[i]=1 for one clk and hold_cnt clears.
REQ-022 HELD with repeat_en[i]=0: no repeat pulses and hold_cnt held at 0; re-enabling restarts a full REPEAT_TICKS interval.
REQ-023 Any state on debounced falling level -> IDLE, release_out[i]=1 for one clk, hold_cnt cleared.
REQ-024 If a falling level and a long or repeat threshold fall in the same clk, release SHALL win: release_out pulses; long_out and ButtonOut stay 0.
REQ-025 Channels SHALL be fully independent; simultaneous events on different channels SHALL each pulse in the same clk.
REQ-026 No output pulse SHALL exceed one clk; a channel's ButtonOut, release_out and long_out SHALL never be high in the same clk.
REQ-027 Counter widths SHALL be $clog2-sized to the parameter maximum; counters SHALL never wrap past their threshold.

Reset
REQ-028 reset=0 SHALL asynchronously clear synchronizers, tick counter, deb_cnt, hold_cnt and level; all FSMs go to IDLE; all outputs go to 0.
REQ-029 A button held through reset release SHALL debounce from level 0 and yield one normal press pulse; there is no pulse during reset.

Verification (sim=1, N=4, DEB_SAMPLES=4, LONG_TICKS=8, REPEAT_TICKS=3)
REQ-030 Clean press of ch0, held 6 ticks then released -> exactly one ButtonOut[0] pulse within 19 clk of the edge, one release_out[0] pulse, long_out=0.
REQ-031 ch1 bounce 0-1-0 lasting 3 ticks -> level_out[1] stays 0 and no pulses on any output.
REQ-032 ch2 held 20 ticks with repeat_en[2]=1 -> one press pulse, long_out[2] at 8 ticks after press, repeat pulses every 3 ticks, one release pulse.
REQ-033 Same as REQ-032 but repeat_en[2]=0 -> one press pulse, one long pulse, zero repeats.
REQ-034 ch0 and ch3 pressed in the same clk -> ButtonOut=4'b1001 for one clk.
REQ-035 reset asserted mid-HELD on ch2 -> all outputs 0 immediately; after reset release with the button still held, one fresh press pulse after debounce.
